// File: rtl/vpd_responder.sv
// VPD word store answering cfg_vpd_* requests with a fixed-latency done pulse.
// Low words are write-protected product data; bad accesses are flagged with done.
module vpd_responder #(
   parameter int VPD_WORDS  = 256,
   parameter int WP_WORDS   = 64,
   parameter int ACCESS_LAT = 2
) (
   input  logic        clock_tlx,
   input  logic        reset_afu_n,
   input  logic [14:0] cfg_vpd_addr,
   input  logic        cfg_vpd_wren,
   input  logic [31:0] cfg_vpd_wdata,
   input  logic        cfg_vpd_rden,
   output logic [31:0] vpd_cfg_rdata,
   output logic        vpd_cfg_done,
   output logic        vpd_err_unimplemented_addr,
   output logic        vpd_err_write_protect,
   output logic        vpd_busy
);
   // state    | meaning
   // IDLE     | waiting for rden or wren, request captured on the edge
   // BUSY     | counting down ACCESS_LAT-1; access performed when cnt==0
   // DONE     | done (and any error) asserted for this one cycle
   // WAIT_REL | waiting for the requester to drop rden and wren

   localparam int AW = $clog2(VPD_WORDS);
   localparam logic [31:0] VPD_WORDS_U = 32'(VPD_WORDS);
   localparam logic [31:0] WP_WORDS_U  = 32'(WP_WORDS);
   localparam logic [3:0]  CNT_LOAD    = 4'(ACCESS_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_BUSY     = 2'd1,
      S_DONE     = 2'd2,
      S_WAIT_REL = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [14:0] addr_q;
   logic [31:0] wdata_q;
   logic        rden_q, wren_q;
   logic [3:0]  cnt;
   logic [31:0] rdata_q;
   logic        err_unimp_q, err_wp_q;
   logic [31:0] mem [VPD_WORDS];

   logic [12:0] idx;
   logic        req, bad, wp_hit, access, mem_we, rd_ok;

   always_comb begin
      idx    = addr_q[14:2];
      req    = cfg_vpd_rden | cfg_vpd_wren;
      bad    = (addr_q[1:0] != 2'b00) || ({19'd0, idx} >= VPD_WORDS_U) || (rden_q && wren_q);
      wp_hit = wren_q && ({19'd0, idx} < WP_WORDS_U);
      access = (state == S_BUSY) && (cnt == 4'd0);
      mem_we = access && wren_q && !bad && !wp_hit;
      rd_ok  = rden_q && !bad;
   end

   always_ff @(posedge clock_tlx or negedge reset_afu_n) begin
      if (!reset_afu_n) state <= S_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (req) state_nxt = S_BUSY;
         S_BUSY:     if (cnt == 4'd0) state_nxt = S_DONE;
         S_DONE:     state_nxt = S_WAIT_REL;
         S_WAIT_REL: if (!req) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_tlx or negedge reset_afu_n) begin
      if (!reset_afu_n) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         rden_q      <= 1'b0;
         wren_q      <= 1'b0;
         cnt         <= '0;
         rdata_q     <= '0;
         err_unimp_q <= 1'b0;
         err_wp_q    <= 1'b0;
      end else begin
         if (state == S_IDLE && req) begin
            addr_q  <= cfg_vpd_addr;
            wdata_q <= cfg_vpd_wdata;
            rden_q  <= cfg_vpd_rden;
            wren_q  <= cfg_vpd_wren;
            cnt     <= CNT_LOAD;
         end else if (state == S_BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (access) begin
            rdata_q     <= rd_ok ? mem[idx[AW-1:0]] : 32'd0;
            err_unimp_q <= bad;
            err_wp_q    <= !bad && wp_hit;
         end
      end
   end

   // storage is deliberately not reset
   always_ff @(posedge clock_tlx) begin
      if (mem_we) mem[idx[AW-1:0]] <= wdata_q;
   end

   assign vpd_cfg_done               = (state == S_DONE);
   assign vpd_cfg_rdata              = rdata_q;
   assign vpd_err_unimplemented_addr = err_unimp_q && (state == S_DONE);
   assign vpd_err_write_protect      = err_wp_q && (state == S_DONE);
   assign vpd_busy                   = (state != S_IDLE);

endmodule

// File: tb/tb_vpd_responder.sv
// Directed bench for vpd_responder with default parameters (256 words, 64 protected, latency 2).
module tb_vpd_responder;
   logic        clock_tlx = 1'b0;
   logic        reset_afu_n;
   logic [14:0] cfg_vpd_addr;
   logic        cfg_vpd_wren;
   logic [31:0] cfg_vpd_wdata;
   logic        cfg_vpd_rden;
   logic [31:0] vpd_cfg_rdata;
   logic        vpd_cfg_done;
   logic        vpd_err_unimplemented_addr;
   logic        vpd_err_write_protect;
   logic        vpd_busy;

   int tests = 0;
   int fails = 0;

   vpd_responder dut (
      .clock_tlx                  (clock_tlx),
      .reset_afu_n                (reset_afu_n),
      .cfg_vpd_addr               (cfg_vpd_addr),
      .cfg_vpd_wren               (cfg_vpd_wren),
      .cfg_vpd_wdata              (cfg_vpd_wdata),
      .cfg_vpd_rden               (cfg_vpd_rden),
      .vpd_cfg_rdata              (vpd_cfg_rdata),
      .vpd_cfg_done               (vpd_cfg_done),
      .vpd_err_unimplemented_addr (vpd_err_unimplemented_addr),
      .vpd_err_write_protect      (vpd_err_write_protect),
      .vpd_busy                   (vpd_busy)
   );

   always #5 clock_tlx = ~clock_tlx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives a request, waits (bounded) for done and samples the outputs in the done cycle.
   logic [31:0] r_data;
   logic        r_unimp, r_wp;
   int          r_cycles;

   task automatic request(input logic rd, input logic wr, input logic [14:0] addr,
                          input logic [31:0] wdata, input logic hold);
      logic got;
      got = 1'b0;
      @(negedge clock_tlx);
      cfg_vpd_rden  = rd;
      cfg_vpd_wren  = wr;
      cfg_vpd_addr  = addr;
      cfg_vpd_wdata = wdata;
      r_cycles = 0;
      while (!got && r_cycles < 20) begin
         @(posedge clock_tlx); #1;
         r_cycles++;
         if (vpd_cfg_done) begin
            got     = 1'b1;
            r_data  = vpd_cfg_rdata;
            r_unimp = vpd_err_unimplemented_addr;
            r_wp    = vpd_err_write_protect;
         end
      end
      check("done_seen", {31'd0, got}, 32'd1);
      // inputs changing after capture must not matter
      cfg_vpd_addr  = 15'h7fff;
      cfg_vpd_wdata = 32'hFFFF_FFFF;
      if (!hold) begin
         cfg_vpd_rden = 1'b0;
         cfg_vpd_wren = 1'b0;
         repeat (3) @(posedge clock_tlx);
         #1;
      end
   endtask

   logic [31:0] word4_before;
   int          extra_done;
   int          busy_low;

   initial begin
      reset_afu_n   = 1'b0;
      cfg_vpd_addr  = '0;
      cfg_vpd_wren  = 1'b0;
      cfg_vpd_wdata = '0;
      cfg_vpd_rden  = 1'b0;
      repeat (3) @(posedge clock_tlx);
      #1;
      check("rst_done",  {31'd0, vpd_cfg_done}, 32'd0);
      check("rst_busy",  {31'd0, vpd_busy}, 32'd0);
      check("rst_rdata", vpd_cfg_rdata, 32'd0);
      check("rst_errs",  {30'd0, vpd_err_unimplemented_addr, vpd_err_write_protect}, 32'd0);
      @(negedge clock_tlx);
      reset_afu_n = 1'b1;

      // 1: write then read an unprotected, implemented word (0x0200 = word 0x80)
      request(1'b0, 1'b1, 15'h0200, 32'hDEADBEEF, 1'b0);
      check("wr_latency", 32'(r_cycles), 32'd3);
      check("wr_errs",    {30'd0, r_unimp, r_wp}, 32'd0);
      check("wr_rdata",   r_data, 32'd0);
      request(1'b1, 1'b0, 15'h0200, 32'h0, 1'b0);
      check("rd_data",    r_data, 32'hDEADBEEF);
      check("rd_errs",    {30'd0, r_unimp, r_wp}, 32'd0);
      check("rd_latency", 32'(r_cycles), 32'd3);
      check("rdata_held", vpd_cfg_rdata, 32'hDEADBEEF);

      // 2: held request yields exactly one done
      request(1'b1, 1'b0, 15'h0200, 32'h0, 1'b1);
      extra_done = 0;
      busy_low   = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock_tlx); #1;
         if (vpd_cfg_done) extra_done++;
         if (!vpd_busy) busy_low++;
      end
      check("held_extra_done", 32'(extra_done), 32'd0);
      check("held_busy_low",   32'(busy_low), 32'd0);
      cfg_vpd_rden = 1'b0;
      @(posedge clock_tlx); #1;
      check("release_busy", {31'd0, vpd_busy}, 32'd0);

      // 3: misaligned and out-of-range reads
      request(1'b1, 1'b0, 15'h0402, 32'h0, 1'b0);
      check("misalign_unimp", {31'd0, r_unimp}, 32'd1);
      check("misalign_wp",    {31'd0, r_wp}, 32'd0);
      check("misalign_rdata", r_data, 32'd0);
      request(1'b1, 1'b0, 15'h0400, 32'h0, 1'b0);
      check("range_unimp", {31'd0, r_unimp}, 32'd1);
      check("range_rdata", r_data, 32'd0);
      request(1'b1, 1'b0, 15'h7ffc, 32'h0, 1'b0);
      check("range_top_unimp", {31'd0, r_unimp}, 32'd1);
      request(1'b1, 1'b0, 15'h03fc, 32'h0, 1'b0);
      check("last_word_unimp", {31'd0, r_unimp}, 32'd0);

      // 4: write-protected word keeps its contents
      request(1'b1, 1'b0, 15'h0010, 32'h0, 1'b0);
      word4_before = r_data;
      request(1'b0, 1'b1, 15'h0010, 32'h12345678, 1'b0);
      check("wp_flag",  {31'd0, r_wp}, 32'd1);
      check("wp_unimp", {31'd0, r_unimp}, 32'd0);
      check("wp_rdata", r_data, 32'd0);
      request(1'b1, 1'b0, 15'h0010, 32'h0, 1'b0);
      check("wp_unchanged", r_data, word4_before);
      // first unprotected word (64) is writable
      request(1'b0, 1'b1, 15'h0100, 32'hA5A5_0064, 1'b0);
      check("wp_edge_flag", {31'd0, r_wp}, 32'd0);
      request(1'b1, 1'b0, 15'h0100, 32'h0, 1'b0);
      check("wp_edge_data", r_data, 32'hA5A5_0064);

      // 5: simultaneous rden and wren is a bad access, no write
      request(1'b1, 1'b1, 15'h0200, 32'h0BAD_0BAD, 1'b0);
      check("both_unimp", {31'd0, r_unimp}, 32'd1);
      check("both_wp",    {31'd0, r_wp}, 32'd0);
      check("both_rdata", r_data, 32'd0);
      request(1'b1, 1'b0, 15'h0200, 32'h0, 1'b0);
      check("both_keep", r_data, 32'hDEADBEEF);

      // 6: reset during BUSY aborts a write
      request(1'b0, 1'b1, 15'h0204, 32'h1111_1111, 1'b0);
      @(negedge clock_tlx);
      cfg_vpd_wren  = 1'b1;
      cfg_vpd_addr  = 15'h0204;
      cfg_vpd_wdata = 32'h2222_2222;
      @(posedge clock_tlx); #1;
      check("abort_busy_before", {31'd0, vpd_busy}, 32'd1);
      reset_afu_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, vpd_busy}, 32'd0);
      check("abort_done", {31'd0, vpd_cfg_done}, 32'd0);
      cfg_vpd_wren = 1'b0;
      extra_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock_tlx); #1;
         if (vpd_cfg_done) extra_done++;
      end
      check("abort_no_done", 32'(extra_done), 32'd0);
      @(negedge clock_tlx);
      reset_afu_n = 1'b1;
      request(1'b1, 1'b0, 15'h0204, 32'h0, 1'b0);
      check("abort_storage", r_data, 32'h1111_1111);
      check("abort_latency", 32'(r_cycles), 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
